// File: rtl/proc_pkg.sv
// Shared definitions for the processor core: sequencer states and datapath widths.
package proc_pkg;

  // Instruction word width delivered by instruction memory.
  localparam int INSTR_W = 32;

  // Default program-counter width, in words.
  localparam int PC_W_DEFAULT = 30;

  // Width of the fetch wait counter; large enough for any timeout up to 255.
  localparam int WAIT_W = 8;

  // Instruction sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    FAULT = 3'd4
  } state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction sequencer: owns the PC, fetches each instruction over a req/ack
// handshake, issues it to the datapath, waits for completion and resolves the
// branch/jump flags into the next PC. A fetch that is never acknowledged parks
// the controller in a sticky FAULT state until reset.
module fetch_ctrl
  import proc_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic               issue,
  input  logic               exe_done,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  input  logic [PC_W-1:0]    target,
  output logic               redirect,
  output logic               fault
);

  // The last ack-less FETCH cycle before timing out has the counter at MAX_WAIT-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [PC_W-1:0]   PC_ONE    = PC_W'(1);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
  logic                redirect_q, redirect_d;

  logic                completing;
  logic                takeTarget;
  logic [PC_W-1:0]     pcNext;

  // State register; reset wins over any simultaneous ack or completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack on the final allowed wait cycle still wins over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          state_d = ISSUE;
        end else if (waitCnt_q == WAIT_LAST) begin
          state_d = FAULT;
        end
      end
      ISSUE: begin
        state_d = EXEC;
      end
      EXEC: begin
        if (exe_done) state_d = run ? FETCH : IDLE;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from state or taken straight from registers, never from inputs.
  always_comb begin
    imem_req    = 1'b0;
    issue       = 1'b0;
    fault       = 1'b0;
    imem_addr   = pc_q;
    pc          = pc_q;
    instruction = instr_q;
    redirect    = redirect_q;
    unique case (state_q)
      FETCH:   imem_req = 1'b1;
      ISSUE:   issue    = 1'b1;
      FAULT:   fault    = 1'b1;
      default: ;
    endcase
  end

  // Next-PC resolution; jump outranks a taken branch, fall-through wraps at 2^PC_W.
  always_comb begin
    completing = (state_q == EXEC) && exe_done;
    takeTarget = jump || (branch && zero);
    pcNext     = takeTarget ? target : (pc_q + PC_ONE);
  end

  // Datapath next values: wait counter, instruction latch, PC and redirect pulse.
  always_comb begin
    waitCnt_d  = '0;
    instr_d    = instr_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    if ((state_q == FETCH) && !imem_ack) begin
      waitCnt_d = waitCnt_q + WAIT_ONE;
    end
    if ((state_q == FETCH) && imem_ack) begin
      instr_d = imem_rdata;
    end
    if (completing) begin
      pc_d       = pcNext;
      redirect_d = takeTarget;
    end
  end

  // Datapath registers; the counter is zero whenever FETCH is entered from elsewhere.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      waitCnt_q  <= '0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      waitCnt_q  <= waitCnt_d;
      redirect_q <= redirect_d;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-sequencing controller for the processor core. Owns the 30-bit word-addressed program counter, fetches each instruction from instruction memory over a req/ack handshake, issues it to the datapath, and waits for the datapath's completion. On completion it resolves the `branch`, `zero` and `jump` flags into the next PC. It sits between instruction memory and the execute datapath and is the only writer of `pc`.

## Interface
- `PC_W`, 30, PC width in words.
- `RESET_PC`, 0, PC value loaded on reset.
- `MAX_WAIT`, 15, number of FETCH cycles without `imem_ack` before a fault (1..255).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `run`  in  1  execution enable; sampled in IDLE and at completion.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_W  fetch word address; always equals `pc`.
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instruction`  out  32  latched instruction register.
- `pc`  out  PC_W  address of the current instruction.
- `issue`  out  1  one-cycle pulse: `instruction` is valid for the datapath.
- `exe_done`  in  1  datapath has finished the issued instruction.
- `branch`, `zero`, `jump`  in  1 each  datapath resolution flags, qualified by `exe_done`.
- `target`  in  PC_W  branch/jump destination word address, qualified by `exe_done`.
- `redirect`  out  1  one-cycle pulse when a taken branch or jump updates `pc`.
- `fault`  out  1  sticky fetch-timeout flag.

## Operation
- States: IDLE, FETCH, ISSUE, EXEC, FAULT.
- IDLE: if `run`=1, go to FETCH.
- FETCH: `imem_req`=1 and `imem_addr` is held. On `imem_ack`, latch `imem_rdata` into `instruction` and go to ISSUE. Otherwise increment the wait counter. When the counter reaches `MAX_WAIT` with no ack, go to FAULT.
- ISSUE: `issue`=1 for exactly one cycle, then go to EXEC.
- EXEC: wait for `exe_done`. `exe_done` is ignored in every other state.
- On `exe_done`, compute the next PC:
  - `jump` → `target`
  - else if `branch`&`zero` → `target`
  - else `pc`+1, modulo 2^PC_W (0x3FFFFFFF wraps to 0).
  - `jump` takes priority over `branch`.
- After `exe_done`, go to FETCH if `run`=1, else IDLE. Deasserting `run` mid-instruction never aborts it.
- FAULT: `fault`=1 and `imem_req`=0. Exit only by reset.
- The wait counter clears on every entry to FETCH.

## Timing
- Reset values: state IDLE, `pc`=RESET_PC, `instruction`=0, `imem_req`=0, `issue`=0, `redirect`=0, `fault`=0, wait counter 0.
- Reset has priority over all events, including a simultaneous `imem_ack` or `exe_done`. A reset mid-fetch abandons the request; a late `imem_ack` in IDLE is ignored.
- Fastest instruction: 3 cycles (FETCH with immediate ack, ISSUE, EXEC with immediate `exe_done`).
- `instruction` is updated on the edge that leaves FETCH and is stable through ISSUE and EXEC.
- `pc` and `redirect` update on the edge that samples `exe_done`. `imem_addr` shows the new PC in the following FETCH cycle.
- Timeout: FAULT is entered on the edge ending the MAX_WAIT-th ack-less FETCH cycle. An ack arriving in that same cycle wins and goes to ISSUE.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package `proc_pkg` holds:
  - the state enum (IDLE, FETCH, ISSUE, EXEC, FAULT)
  - the 32-bit instruction width constant
  - the default PC width constant
- Single module with no sub-modules. The next-PC mux stays inline.

## Test plan
- Reset then `run`=1, with ack on the first FETCH cycle and `exe_done` on the first EXEC cycle, no flags → `issue` every 3 cycles; `pc` goes 0,1,2,3.
- In EXEC at `pc`=5, `exe_done` with `branch`=1, `zero`=1, `target`=0x40 → `pc`=0x40, `redirect` pulses. Same with `zero`=0 → `pc`=6, no redirect.
- `exe_done` with `jump`=1, `branch`=1, `zero`=0, `target`=0x100 → `pc`=0x100 (jump priority).
- `pc`=0x3FFFFFFF, no flags → `pc` wraps to 0.
- Hold `imem_ack`=0 for 15 FETCH cycles → `fault`=1, `imem_req`=0, remains until `rst`=0. Ack arriving on the 15th cycle → normal ISSUE.
- Drop `run` during EXEC → instruction completes, FSM returns to IDLE with no new `imem_req`. Assert `rst`=0 during FETCH → all outputs return to reset values on the next edge.
